// File: rtl/fetch_unit_pkg.sv
// Shared fetch_unit definitions: command encodings (also used by the control FSM),
// state encodings and a small PC arithmetic helper.
package fetch_unit_pkg;

  localparam logic [1:0] FCMD_INSTR   = 2'b00;
  localparam logic [1:0] FCMD_OPERAND = 2'b01;
  localparam logic [1:0] FCMD_JUMP    = 2'b10;
  localparam logic [1:0] FCMD_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_HI  = 3'd1,
    ST_RD_LO  = 3'd2,
    ST_FINISH = 3'd3,
    ST_FAULT  = 3'd4
  } fetch_state_e;

  // 16-bit address step with natural wrap at 2^16
  function automatic logic [15:0] addr_step(input logic [15:0] base, input logic [15:0] step);
    return base + step;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Per-byte wait counter for fetch_unit; expired is asserted on the tick that
// would complete TIMEOUT_CYCLES waiting cycles. Only built with FETCH_TIMEOUT_EN.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_r;

  // wait-cycle counter, clear wins over tick
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = tick && !clear && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction / operand / jump-target fetcher over a byte-wide program memory; owns the PC.
// Optional per-byte read timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd,
  input  logic        cmd_operand_sel,
  output logic        done,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] instruction,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic [15:0] pc,
  output logic        err,
  output logic        fault
);

  fetch_state_e state_r, state_s;
  logic [1:0]  cmd_r, cmd_s;
  logic        sel_r, sel_s;
  logic [15:0] base_r, base_s;
  logic [7:0]  hi_r, hi_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] instr_r, instr_s;
  logic [15:0] opa_r, opa_s;
  logic [15:0] opb_r, opb_s;
  logic        mem_rd_r, mem_rd_s;
  logic [15:0] mem_addr_r, mem_addr_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        fault_r, fault_s;
  logic        ready_r;
  logic        wd_expired_s;
  logic [15:0] word_s;

  assign word_s = {hi_r, mem_rdata};

`ifdef FETCH_TIMEOUT_EN
  logic wd_clear_s;
  logic wd_tick_s;

  assign wd_clear_s = (state_r == ST_IDLE && cmd_valid && cmd != FCMD_RSVD) || mem_valid;
  assign wd_tick_s  = (state_r == ST_RD_HI) || (state_r == ST_RD_LO);

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear_s),
    .tick   (wd_tick_s),
    .expired(wd_expired_s)
  );
`else
  assign wd_expired_s = 1'b0;
`endif

  // next-state and next register values
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    sel_s      = sel_r;
    base_s     = base_r;
    hi_s       = hi_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    opa_s      = opa_r;
    opb_s      = opb_r;
    mem_rd_s   = mem_rd_r;
    mem_addr_s = mem_addr_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    fault_s    = fault_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_s  = cmd;
          sel_s  = cmd_operand_sel;
          base_s = pc_r;
          if (cmd == FCMD_RSVD) begin
            state_s = ST_FINISH;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s    = ST_RD_HI;
            mem_rd_s   = 1'b1;
            mem_addr_s = pc_r;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_HI: begin
        if (mem_valid) begin
          hi_s       = mem_rdata;
          state_s    = ST_RD_LO;
          mem_addr_s = addr_step(base_r, 16'd1);
        end else if (wd_expired_s) begin
          state_s  = ST_FAULT;
          mem_rd_s = 1'b0;
          fault_s  = 1'b1;
        end else begin
          state_s = ST_RD_HI;
        end
      end
      ST_RD_LO: begin
        if (mem_valid) begin
          state_s  = ST_FINISH;
          mem_rd_s = 1'b0;
          done_s   = 1'b1;
          // destination updates on the edge entering FINISH
          case (cmd_r)
            FCMD_INSTR: begin
              instr_s = word_s;
              pc_s    = addr_step(pc_r, 16'd2);
            end
            FCMD_OPERAND: begin
              if (sel_r) begin
                opb_s = word_s;
              end else begin
                opa_s = word_s;
              end
              pc_s = addr_step(pc_r, 16'd2);
            end
            FCMD_JUMP: begin
              pc_s = word_s;
            end
            default: begin
              pc_s = pc_r;
            end
          endcase
        end else if (wd_expired_s) begin
          state_s  = ST_FAULT;
          mem_rd_s = 1'b0;
          fault_s  = 1'b1;
        end else begin
          state_s = ST_RD_LO;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      ST_FAULT: begin
        state_s = ST_FAULT;
      end
      default: begin
        state_s  = ST_IDLE;
        mem_rd_s = 1'b0;
      end
    endcase
  end

  // state and registered outputs; reset overrides any pending update
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cmd_r      <= FCMD_INSTR;
      sel_r      <= 1'b0;
      base_r     <= PC_RESET;
      hi_r       <= 8'h00;
      pc_r       <= PC_RESET;
      instr_r    <= 16'h0000;
      opa_r      <= 16'h0000;
      opb_r      <= 16'h0000;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= PC_RESET;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      fault_r    <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      sel_r      <= sel_s;
      base_r     <= base_s;
      hi_r       <= hi_s;
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      opa_r      <= opa_s;
      opb_r      <= opb_s;
      mem_rd_r   <= mem_rd_s;
      mem_addr_r <= mem_addr_s;
      done_r     <= done_s;
      err_r      <= err_s;
      fault_r    <= fault_s;
      ready_r    <= (state_s == ST_IDLE);
    end
  end

  assign cmd_ready   = ready_r;
  assign done        = done_r;
  assign err         = err_r;
  assign fault       = fault_r;
  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign instruction = instr_r;
  assign operand_a   = opa_r;
  assign operand_b   = opb_r;
  assign pc          = pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a byte memory model
// that supports programmable wait states, stalls and stray mem_valid.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic        cmd_operand_sel;
  logic        done;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic [15:0] instruction;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [15:0] pc;
  logic        err;
  logic        fault;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [0:65535];
  int  waits = 0;
  int  wcnt  = 0;
  bit  stall = 1'b0;
  bit  stale_valid = 1'b0;

  fetch_unit #(.PC_RESET(16'h0000), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_operand_sel(cmd_operand_sel), .done(done), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .instruction(instruction), .operand_a(operand_a), .operand_b(operand_b),
    .pc(pc), .err(err), .fault(fault)
  );

  always #5 clock = ~clock;

  assign mem_valid = (mem_rd && !stall && (wcnt >= waits)) || stale_valid;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_rd && !mem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Issue one command from IDLE (called #1 after an edge); returns in the next IDLE cycle.
  task automatic run_cmd(input logic [1:0] c, input logic s, input bit poke,
                         output int lat, output logic [15:0] a_first, output logic [15:0] a_second,
                         output bit rd_seen, output bit err_seen, output bit ready_busy);
    cmd = c; cmd_operand_sel = s; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = poke;
    if (poke) cmd = 2'b10;
    lat = 1; rd_seen = 1'b0; a_first = 16'h0000; a_second = 16'h0000; ready_busy = 1'b0;
    while (!done && lat < 200) begin
      if (cmd_ready) ready_busy = 1'b1;
      if (mem_rd) begin
        if (!rd_seen) a_first = mem_addr;
        else if (mem_addr != a_first) a_second = mem_addr;
        rd_seen = 1'b1;
      end
      @(posedge clock); #1;
      lat++;
    end
    if (mem_rd) rd_seen = 1'b1;
    err_seen = err;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_operand_sel = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", pc); else passed++;
    checks++; if ({instruction, operand_a, operand_b} !== 48'h0) $display("FAIL reset_regs: got %h expected 0", {instruction, operand_a, operand_b}); else passed++;
    checks++; if ({mem_rd, done, err, fault} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {mem_rd, done, err, fault}); else passed++;
    checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_addr: got %h expected 0000", mem_addr); else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else passed++;
  endtask

  task automatic test_fetch_instr();
    int lat; logic [15:0] a1, a2; bit rd, e, rb;
    waits = 0;
    run_cmd(2'b00, 1'b0, 1'b0, lat, a1, a2, rd, e, rb);
    checks++; if (lat !== 3) $display("FAIL instr_latency: got %0d expected 3", lat); else passed++;
    checks++; if ({a1, a2} !== {16'h0000, 16'h0001}) $display("FAIL instr_addrs: got %h %h expected 0000 0001", a1, a2); else passed++;
    checks++; if (instruction !== 16'h6801) $display("FAIL instr_value: got %h expected 6801", instruction); else passed++;
    checks++; if (pc !== 16'h0002) $display("FAIL instr_pc: got %h expected 0002", pc); else passed++;
  endtask

  task automatic test_operands();
    int lat; logic [15:0] a1, a2; bit rd, e, rb;
    waits = 2;
    run_cmd(2'b01, 1'b0, 1'b1, lat, a1, a2, rd, e, rb);
    checks++; if (lat !== 7) $display("FAIL opa_latency: got %0d expected 7", lat); else passed++;
    checks++; if (operand_a !== 16'h1234) $display("FAIL opa_value: got %h expected 1234", operand_a); else passed++;
    checks++; if (pc !== 16'h0004) $display("FAIL opa_pc_busy_ignored: got %h expected 0004", pc); else passed++;
    checks++; if (rb !== 1'b0) $display("FAIL busy_ready: got %b expected 0", rb); else passed++;
    run_cmd(2'b01, 1'b1, 1'b0, lat, a1, a2, rd, e, rb);
    checks++; if (lat !== 7) $display("FAIL opb_latency: got %0d expected 7", lat); else passed++;
    checks++; if (operand_b !== 16'hABCD) $display("FAIL opb_value: got %h expected abcd", operand_b); else passed++;
    checks++; if (pc !== 16'h0006) $display("FAIL opb_pc: got %h expected 0006", pc); else passed++;
    checks++; if ({instruction, operand_a} !== {16'h6801, 16'h1234}) $display("FAIL hold_regs: got %h expected 68011234", {instruction, operand_a}); else passed++;
  endtask

  task automatic test_jump_wrap();
    int lat; logic [15:0] a1, a2; bit rd, e, rb;
    waits = 0;
    run_cmd(2'b10, 1'b0, 1'b0, lat, a1, a2, rd, e, rb);
    checks++; if (pc !== 16'hFFFF) $display("FAIL jump_pc: got %h expected ffff", pc); else passed++;
    checks++; if (instruction !== 16'h6801) $display("FAIL jump_keeps_instr: got %h expected 6801", instruction); else passed++;
    mem[16'hFFFF] = 8'h12; mem[0] = 8'h34;
    run_cmd(2'b00, 1'b0, 1'b0, lat, a1, a2, rd, e, rb);
    checks++; if ({a1, a2} !== {16'hFFFF, 16'h0000}) $display("FAIL wrap_addrs: got %h %h expected ffff 0000", a1, a2); else passed++;
    checks++; if (instruction !== 16'h1234) $display("FAIL wrap_instr: got %h expected 1234", instruction); else passed++;
    checks++; if (pc !== 16'h0001) $display("FAIL wrap_pc: got %h expected 0001", pc); else passed++;
  endtask

  task automatic test_reserved();
    int lat; logic [15:0] a1, a2; bit rd, e, rb;
    run_cmd(2'b11, 1'b0, 1'b0, lat, a1, a2, rd, e, rb);
    checks++; if (lat !== 1) $display("FAIL rsvd_latency: got %0d expected 1", lat); else passed++;
    checks++; if (e !== 1'b1) $display("FAIL rsvd_err: got %b expected 1", e); else passed++;
    checks++; if (rd !== 1'b0) $display("FAIL rsvd_no_read: got %b expected 0", rd); else passed++;
    checks++; if ({pc, instruction, operand_a, operand_b} !== 64'h0001_1234_1234_ABCD)
      $display("FAIL rsvd_no_change: got %h expected 0001123412 34abcd", {pc, instruction, operand_a, operand_b}); else passed++;
    checks++; if ({err, done} !== 2'b00) $display("FAIL rsvd_pulse_len: got %b expected 00", {err, done}); else passed++;
  endtask

  task automatic test_reset_midop();
    bit saw_done;
    waits = 0; saw_done = 1'b0;
    cmd = 2'b00; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    stall = 1'b1;
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'h0002}) $display("FAIL midop_rd_lo: got %b %h expected 1 0002", mem_rd, mem_addr); else passed++;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; stale_valid = 1'b1; stall = 1'b0;
    saw_done = saw_done | done;
    checks++; if (mem_rd !== 1'b0) $display("FAIL midop_rd_off: got %b expected 0", mem_rd); else passed++;
    checks++; if ({pc, instruction} !== 32'h0000_0000) $display("FAIL midop_regs: got %h expected 00000000", {pc, instruction}); else passed++;
    @(posedge clock); #1;
    stale_valid = 1'b0;
    saw_done = saw_done | done;
    checks++; if (saw_done !== 1'b0) $display("FAIL midop_no_done: got %b expected 0", saw_done); else passed++;
    checks++; if ({cmd_ready, mem_rd, instruction} !== {2'b10, 16'h0000}) $display("FAIL midop_idle: got %b %b %h expected 1 0 0000", cmd_ready, mem_rd, instruction); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    stall = 1'b1;
    cmd = 2'b00; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    while (!fault && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    checks++; if (n !== 16) $display("FAIL timeout_cycles: got %0d expected 16", n); else passed++;
    checks++; if ({mem_rd, done} !== 2'b00) $display("FAIL timeout_rd: got %b expected 00", {mem_rd, done}); else passed++;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    checks++; if ({cmd_ready, fault, mem_rd} !== 3'b010) $display("FAIL fault_terminal: got %b expected 010", {cmd_ready, fault, mem_rd}); else passed++;
`else
    for (n = 0; n < 40; n++) begin
      @(posedge clock); #1;
    end
    checks++; if ({fault, mem_rd, cmd_ready, done} !== 4'b0100) $display("FAIL stall_wait: got %b expected 0100", {fault, mem_rd, cmd_ready, done}); else passed++;
`endif
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; stall = 1'b0;
    @(posedge clock); #1;
    checks++; if ({fault, cmd_ready, mem_rd} !== 3'b010) $display("FAIL timeout_reset: got %b expected 010", {fault, cmd_ready, mem_rd}); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h68; mem[1] = 8'h01;
    mem[2] = 8'h12; mem[3] = 8'h34; mem[4] = 8'hAB; mem[5] = 8'hCD;
    mem[6] = 8'hFF; mem[7] = 8'hFF;
    test_reset();
    test_fetch_instr();
    test_operands();
    test_jump_wrap();
    test_reserved();
    test_reset_midop();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
